// File: rtl/seq_alu.sv
// seq_alu: registered ALU. ADD/SUB/ADC/AND/ORR/EOR complete in one cycle.
// MUL/MLA iterate radix-2 shift-add over WIDTH cycles.
// Flags are reported as {N,Z,C,V}.
//
// Handshake: start_i is sampled on a rising edge only while busy_o is low.
// There is no ready signal; a start seen while busy_o is high is dropped.
// done_o pulses for exactly one cycle on each edge that updates
// result_o/flags_o. It stays high across back-to-back single-cycle ops.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] c_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic [3:0]       flags_o,
   output logic             dbg_state_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_ORR = 3'b011;
   localparam logic [2:0] OP_EOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_MLA = 3'b110;
   localparam logic [2:0] OP_ADC = 3'b111;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t             state_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   result_q;
   logic [3:0]         flags_q;
   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CNT_W-1:0]   count_q;

   logic [WIDTH-1:0]   b_eff;
   logic               cin_eff;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic [WIDTH-1:0]   acc_d;

   // Single-cycle datapath. SUB is formed as a + ~b + 1, so the carry means "no borrow".
   always_comb begin
      b_eff   = b_i;
      cin_eff = 1'b0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op_i)
         OP_SUB:  begin b_eff = ~b_i; cin_eff = 1'b1; end
         OP_ADC:  cin_eff = cin_i;
         default: ;
      endcase
      sum = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
      case (op_i)
         OP_AND:  alu_res = a_i & b_i;
         OP_ORR:  alu_res = a_i | b_i;
         OP_EOR:  alu_res = a_i ^ b_i;
         default: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a_i[WIDTH-1]);
         end
      endcase
   end

   // One shift-add step: add the multiplicand when the current multiplier bit is set.
   always_comb begin
      acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   end

   // Control FSM plus registered result, flags and handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  if (op_i == OP_MUL || op_i == OP_MLA) begin
                     acc_q    <= (op_i == OP_MLA) ? c_i : '0;
                     mcand_q  <= a_i;
                     mplier_q <= b_i;
                     count_q  <= CNT_W'(WIDTH);
                     busy_q   <= 1'b1;
                     state_q  <= RUN;
                  end else begin
                     result_q <= alu_res;
                     flags_q  <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
                     done_q   <= 1'b1;
                  end
               end
            end
            RUN: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) begin
                  result_q <= acc_d;
                  flags_q  <= {acc_d[WIDTH-1], (acc_d == '0), 2'b00};
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign result_o    = result_q;
   assign flags_o     = flags_q;
   assign dbg_state_o = (state_q == RUN);

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: drives a 32-bit and an 8-bit seq_alu from the same stimulus.
// Both are checked against an arithmetic reference model.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        cin = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = '0, b = '0, c = '0;

   logic        busy32, done32, st32;
   logic [31:0] res32;
   logic [3:0]  fl32;
   logic        busy8, done8, st8;
   logic [7:0]  res8;
   logic [3:0]  fl8;

   int total = 0;
   int bad = 0;

   logic [2:0]  sop [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
   logic [35:0] exp_q[$];

   // clock
   always #5 clk = ~clk;

   seq_alu #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .start_i(start), .op_i(op),
      .a_i(a), .b_i(b), .c_i(c), .cin_i(cin),
      .busy_o(busy32), .done_o(done32), .result_o(res32), .flags_o(fl32),
      .dbg_state_o(st32)
   );

   seq_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start_i(start), .op_i(op),
      .a_i(a[7:0]), .b_i(b[7:0]), .c_i(c[7:0]), .cin_i(cin),
      .busy_o(busy8), .done_o(done8), .result_o(res8), .flags_o(fl8),
      .dbg_state_o(st8)
   );

   // Reference model: plain w-bit arithmetic, flags from signed/unsigned rules.
   function automatic void model(input int w, input logic [2:0] o,
                                 input longint unsigned ai, input longint unsigned bi,
                                 input longint unsigned ci, input logic cn,
                                 output longint unsigned r, output logic [3:0] f);
      longint unsigned mask, full;
      logic cf, vf;
      int msb;
      mask = (64'd1 << w) - 64'd1;
      msb  = w - 1;
      ai = ai & mask; bi = bi & mask; ci = ci & mask;
      cf = 1'b0; vf = 1'b0; r = 0;
      case (o)
         3'd0, 3'd7: begin
            full = ai + bi + ((o == 3'd7) ? longint'(cn) : 0);
            r    = full & mask;
            cf   = full[w];
            vf   = (ai[msb] == bi[msb]) && (r[msb] != ai[msb]);
         end
         3'd1: begin
            r  = (ai - bi) & mask;
            cf = (ai >= bi);
            vf = (ai[msb] != bi[msb]) && (r[msb] != ai[msb]);
         end
         3'd2: r = ai & bi;
         3'd3: r = ai | bi;
         3'd4: r = ai ^ bi;
         3'd5: r = (ai * bi) & mask;
         default: r = (ai * bi + ci) & mask;
      endcase
      f = {r[msb], (r == 0), cf, vf};
   endfunction

   task automatic scramble();
      a = $urandom; b = $urandom; c = $urandom; cin = 1'($urandom); op = 3'($urandom);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy32, done32, fl32, res32, busy8, done8, fl8, res8} !== '0) begin
         bad++;
         $display("FAIL reset_assert: got b32=%b d32=%b f32=%b r32=%h b8=%b d8=%b f8=%b r8=%h, want all 0",
                  busy32, done32, fl32, res32, busy8, done8, fl8, res8);
      end
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({busy32, done32, fl32, res32, busy8, done8, fl8, res8} !== '0) begin
         bad++;
         $display("FAIL reset_release: got b32=%b d32=%b r32=%h b8=%b d8=%b r8=%h, want all 0",
                  busy32, done32, res32, busy8, done8, res8);
      end
   endtask

   // One single-cycle op: result after E0, then done drops and result holds.
   task automatic run_single(input string name, input logic [2:0] o, input logic [31:0] ai,
                             input logic [31:0] bi, input logic ci_n);
      longint unsigned er, er8;
      logic [3:0] ef, ef8;
      model(32, o, ai, bi, 0, ci_n, er, ef);
      model(8, o, ai, bi, 0, ci_n, er8, ef8);
      @(negedge clk);
      start = 1'b1; op = o; a = ai; b = bi; c = $urandom; cin = ci_n;
      @(posedge clk); #1;
      total++;
      if ({done32, busy32, fl32, res32} !== {2'b10, ef, er[31:0]}) begin
         bad++;
         $display("FAIL %s_w32: got done=%b busy=%b flags=%b result=%h, want done=1 busy=0 flags=%b result=%h",
                  name, done32, busy32, fl32, res32, ef, er[31:0]);
      end
      total++;
      if ({done8, busy8, fl8, res8} !== {2'b10, ef8, er8[7:0]}) begin
         bad++;
         $display("FAIL %s_w8: got done=%b busy=%b flags=%b result=%h, want done=1 busy=0 flags=%b result=%h",
                  name, done8, busy8, fl8, res8, ef8, er8[7:0]);
      end
      @(negedge clk);
      start = 1'b0; scramble();
      @(posedge clk); #1;
      total++;
      if ({done32, fl32, res32, done8, fl8, res8} !== {1'b0, ef, er[31:0], 1'b0, ef8, er8[7:0]}) begin
         bad++;
         $display("FAIL %s_hold: got d32=%b r32=%h d8=%b r8=%h, want d=0 r32=%h r8=%h",
                  name, done32, res32, done8, res8, er[31:0], er8[7:0]);
      end
   endtask

   // MUL/MLA on both widths. inj>0 pulses an ADD start on edge E{inj};
   // rst_at>0 asserts reset just before edge E{rst_at} and ends the task.
   task automatic run_mul(input string name, input logic [2:0] o, input logic [31:0] ai,
                          input logic [31:0] bi, input logic [31:0] ci, input int inj,
                          input int rst_at);
      longint unsigned er, er8;
      logic [3:0] ef, ef8;
      model(32, o, ai, bi, ci, 1'b0, er, ef);
      model(8, o, ai, bi, ci, 1'b0, er8, ef8);
      @(negedge clk);
      start = 1'b1; op = o; a = ai; b = bi; c = ci; cin = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({busy32, done32, busy8, done8} !== 4'b1010) begin
         bad++;
         $display("FAIL %s_e0: got b32=%b d32=%b b8=%b d8=%b, want 1 0 1 0",
                  name, busy32, done32, busy8, done8);
      end
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         scramble();
         start = (k == inj);
         if (k == inj) begin op = 3'd0; a = 32'd1; b = 32'd2; end
         if (rst_at != 0 && k == rst_at) reset = 1'b1;
         @(posedge clk); #1;
         if (rst_at != 0 && k == rst_at) begin
            for (int j = 0; j < 4; j++) begin
               total++;
               if ({busy32, done32, fl32, res32, busy8, done8, fl8, res8} !== '0) begin
                  bad++;
                  $display("FAIL %s_reset_%0d: got b32=%b d32=%b r32=%h b8=%b d8=%b r8=%h, want all 0",
                           name, j, busy32, done32, res32, busy8, done8, res8);
               end
               @(negedge clk); reset = 1'b0; start = 1'b0;
               @(posedge clk); #1;
            end
            return;
         end
         total++;
         if (k < 32) begin
            if ({busy32, done32} !== 2'b10) begin
               bad++;
               $display("FAIL %s_w32_run_%0d: got busy=%b done=%b, want busy=1 done=0",
                        name, k, busy32, done32);
            end
         end else begin
            if ({busy32, done32, fl32, res32} !== {1'b0, (k == 32), ef, er[31:0]}) begin
               bad++;
               $display("FAIL %s_w32_end_%0d: got busy=%b done=%b flags=%b result=%h, want busy=0 done=%b flags=%b result=%h",
                        name, k, busy32, done32, fl32, res32, (k == 32), ef, er[31:0]);
            end
         end
         total++;
         if (k < 8) begin
            if ({busy8, done8} !== 2'b10) begin
               bad++;
               $display("FAIL %s_w8_run_%0d: got busy=%b done=%b, want busy=1 done=0",
                        name, k, busy8, done8);
            end
         end else begin
            if ({busy8, done8, fl8, res8} !== {1'b0, (k == 8), ef8, er8[7:0]}) begin
               bad++;
               $display("FAIL %s_w8_end_%0d: got busy=%b done=%b flags=%b result=%h, want busy=0 done=%b flags=%b result=%h",
                        name, k, busy8, done8, fl8, res8, (k == 8), ef8, er8[7:0]);
            end
         end
      end
   endtask

   task automatic test_add_sub_adc();
      run_single("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      run_single("add_7f", 3'd0, 32'h0000_007F, 32'h0000_0001, 1'b0);
      run_single("sub_eq", 3'd1, 32'd5, 32'd5, 1'b0);
      run_single("sub_neg", 3'd1, 32'd0, 32'd1, 1'b0);
      run_single("adc_c1", 3'd7, 32'hFFFF_FFFF, 32'd0, 1'b1);
      run_single("adc_c0", 3'd7, 32'hFFFF_FFFF, 32'd0, 1'b0);
   endtask

   task automatic test_logic();
      run_single("and", 3'd2, 32'hF0F0_A5A5, 32'hFF00_0FF0, 1'b1);
      run_single("orr", 3'd3, 32'h8000_0000, 32'h0000_0001, 1'b1);
      run_single("eor", 3'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
   endtask

   task automatic test_mul();
      run_mul("mul_ff", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 0);
      run_mul("mla_17", 3'd6, 32'd3, 32'd4, 32'd5, 0, 0);
      run_mul("mul_zero", 3'd5, $urandom, 32'd0, $urandom, 0, 0);
   endtask

   task automatic test_start_while_busy();
      run_mul("mul_busy_start", 3'd5, $urandom, $urandom, 32'd0, 4, 0);
   endtask

   task automatic test_reset_mid_run();
      run_mul("mul_reset", 3'd5, $urandom, $urandom, 32'd0, 0, 10);
      run_single("add_after_reset", 3'd0, 32'd1, 32'd2, 1'b0);
   endtask

   // start held high across several single-cycle ops; done must stay high.
   task automatic test_back_to_back();
      longint unsigned er;
      logic [3:0] ef;
      logic [35:0] exp;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start = 1'b1; op = sop[$urandom_range(0, 5)];
         a = $urandom; b = $urandom; cin = 1'($urandom);
         model(32, op, a, b, 0, cin, er, ef);
         exp_q.push_back({ef, er[31:0]});
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         total++;
         if ({done32, fl32, res32} !== {1'b1, exp}) begin
            bad++;
            $display("FAIL b2b_%0d: got done=%b flags=%b result=%h, want done=1 flags=%b result=%h",
                     i, done32, fl32, res32, exp[35:32], exp[31:0]);
         end
      end
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
      total++;
      if (done32 !== 1'b0) begin
         bad++;
         $display("FAIL b2b_drop: got done=%b, want 0", done32);
      end
   endtask

   task automatic test_random();
      logic [2:0] o;
      for (int i = 0; i < 20; i++) begin
         o = 3'($urandom);
         if (o == 3'd5 || o == 3'd6) run_mul("rnd_mul", o, $urandom, $urandom, $urandom, 0, 0);
         else run_single("rnd", o, $urandom, $urandom, 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_add_sub_adc();
      test_logic();
      test_mul();
      test_start_while_busy();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU for the multi-cycle core. It performs add/sub/logic operations in one cycle and MUL/MLA iteratively over WIDTH cycles, behind a start/busy/done handshake. It sits between the register-file read ports and the writeback mux. It produces NZCV flags in the same {N,Z,C,V} order consumed by the condition/flag-write logic.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 4.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request; sampled on rising edge only when not busy.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 110 MLA, 111 ADC.
- a  in  WIDTH  operand A (multiplicand for MUL/MLA).
- b  in  WIDTH  operand B (multiplier for MUL/MLA).
- c  in  WIDTH  accumulate addend; used only by MLA.
- cin  in  1  carry-in; used only by ADC.
- busy  out  1  high while a MUL/MLA is iterating.
- done  out  1  one-cycle pulse when result/flags are updated.
- result  out  WIDTH  registered result; holds until the next completion.
- flags  out  4  registered {N,Z,C,V}; updated together with result.

## Operation
- States: IDLE and RUN. Reset forces IDLE. All outputs are 0 during and after reset.
- Operands are captured at the start edge. Input changes afterwards have no effect on an operation in flight.
- ADD: a+b. SUB: a+~b+1. ADC: a+b+cin. All computed at WIDTH+1 bits.
  - C = bit WIDTH of the sum.
  - V = (a[MSB]==b'[MSB]) & (sum[MSB]!=a[MSB]), where b' is the inverted b for SUB.
- AND/ORR/EOR: bitwise. C=0, V=0.
- N = result[WIDTH-1]. Z = (result==0). Both apply to every op.
- MUL/MLA use radix-2 shift-add.
  - Start edge loads: acc = 0 (MUL) or c (MLA); mcand = a; mplier = b; count = WIDTH. State goes to RUN.
  - Each RUN edge: if mplier[0], acc += mcand (mod 2^WIDTH); then mcand <<= 1, mplier >>= 1, count -= 1.
  - The edge on which count becomes 0 writes result = acc, sets flags {N,Z,0,0}, pulses done and returns to IDLE.
  - result is the low WIDTH bits of a*b(+c); upper bits are discarded.
- start while busy is ignored entirely: no queueing, no abort.
- start with a single-cycle op in IDLE: state stays IDLE and busy stays 0.
- Reset mid-RUN: immediate return to IDLE. result=0, flags=0, busy=0, done=0, and no done pulse for the aborted op.
- result and flags change only on a done edge or on reset.

## Timing
- Edge E0 samples start.
- Single-cycle ops: result, flags and done=1 are visible after E0. done=0 after E1 unless a new start is sampled at E1.
- Back-to-back single-cycle ops are allowed, with start held high. done stays 1 across consecutive completions.
- MUL/MLA: busy=1 after E0. Iterations run on E1..E{WIDTH}. At E{WIDTH}: result valid, done=1, busy=0. Latency is WIDTH edges.
- A start sampled at the completion edge E{WIDTH} is ignored, because busy was 1 going into that edge. A new start is accepted from E{WIDTH+1}.
- Combinational paths: none from inputs to outputs. All outputs are registered.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, flags 1001, done one cycle after start.
- SUB 5 − 5 → result 0, flags 0110. SUB 0 − 1 → 0xFFFFFFFF, flags 1000.
- ADC 0xFFFFFFFF + 0 with cin=1 → result 0, flags 0110. Same operands with cin=0 → 0xFFFFFFFF, flags 1000.
- MUL 0xFFFFFFFF × 0xFFFFFFFF → result 0x00000001, flags 0000; busy high for exactly 32 cycles, done at E32. MLA 3×4+5 → 17.
- Pulse start with ADD during MUL busy → ignored; MUL result is unaffected and exactly one done pulse occurs. Assert reset at E10 of a MUL → all outputs 0 and no done; a following ADD 1+2 → 3.
- Re-run all cases with WIDTH=8: MUL 0xFF×0xFF → 0x01 after 8 cycles; ADD 0x7F+1 → 0x80, flags 1001.
